// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler: rotating-priority selection of ready
// entries onto up to N issue lanes under per-class and multiplier budgets.
module rs_issue_scheduler #(
  parameter int RS_SZ        = 16,
  parameter int N            = 3,
  parameter int NUM_ALU      = 3,
  parameter int MULT_LATENCY = 4,
  parameter int B_MASK_WIDTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [RS_SZ-1:0]               rs_valid,
  input  logic [RS_SZ-1:0]               rs_src1_ready,
  input  logic [RS_SZ-1:0]               rs_src2_ready,
  input  logic [2*RS_SZ-1:0]             rs_fu_type,
  input  logic [B_MASK_WIDTH*RS_SZ-1:0]  rs_b_mask,
  input  logic [B_MASK_WIDTH-1:0]        b_mm_resolve,
  input  logic                           b_mm_mispred,
  input  logic                           mem_stall,
  output logic [RS_SZ-1:0]               rs_data_issuing,
  output logic [N-1:0]                   issue_valid,
  output logic [N*$clog2(RS_SZ)-1:0]     issue_idx,
  output logic                           mult_busy
);

  localparam int IW = $clog2(RS_SZ);
  localparam int CW = $clog2(MULT_LATENCY + 1);

  typedef enum logic [1:0] {
    FU_ALU    = 2'd0,
    FU_MULT   = 2'd1,
    FU_MEM    = 2'd2,
    FU_BRANCH = 2'd3
  } fu_e;

  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    rr_next;
  logic [CW-1:0]    mult_cnt;
  logic [CW-1:0]    mult_cnt_next;
  logic             mult_busy_q;

  logic [RS_SZ-1:0] squashed;
  logic [RS_SZ-1:0] eligible;
  logic [RS_SZ-1:0] grant;
  logic [N-1:0]     lane_valid;
  logic [N*IW-1:0]  lane_idx;
  logic             any_grant;
  logic             mult_grant;
  logic [IW-1:0]    last_grant;

  assign mult_busy_q = (mult_cnt != '0);

  always_comb begin : eligibility
    squashed = '0;
    eligible = '0;
    for (int unsigned i = 0; i < RS_SZ; i++) begin
      squashed[i] = b_mm_mispred & (|(rs_b_mask[i*B_MASK_WIDTH +: B_MASK_WIDTH] & b_mm_resolve));
      eligible[i] = rs_valid[i] & rs_src1_ready[i] & rs_src2_ready[i] & ~squashed[i];
    end
  end

  // Single pass in rotating order; a budget-blocked entry only sets take=0,
  // so later entries of other classes are still considered.
  always_comb begin : select
    int unsigned n_total;
    int unsigned n_alu;
    int unsigned ii;
    logic        took_mult;
    logic        took_mem;
    logic        took_br;
    logic        take;
    fu_e         fu;

    grant      = '0;
    lane_valid = '0;
    lane_idx   = '0;
    any_grant  = 1'b0;
    mult_grant = 1'b0;
    last_grant = rr_ptr;
    n_total    = 0;
    n_alu      = 0;
    ii         = 0;
    took_mult  = 1'b0;
    took_mem   = 1'b0;
    took_br    = 1'b0;
    take       = 1'b0;
    fu         = FU_ALU;

    for (int unsigned k = 0; k < RS_SZ; k++) begin
      ii   = (32'(rr_ptr) + k) % RS_SZ;
      fu   = fu_e'(rs_fu_type[2*ii +: 2]);
      take = 1'b0;
      if (eligible[ii] && (n_total < N)) begin
        case (fu)
          FU_ALU:    take = (n_alu < NUM_ALU);
          FU_MULT:   take = !took_mult && !mult_busy_q;
          FU_MEM:    take = !took_mem && !mem_stall;
          FU_BRANCH: take = !took_br;
          default:   take = 1'b0;
        endcase
      end
      if (take) begin
        grant[ii]                    = 1'b1;
        lane_valid[n_total]          = 1'b1;
        lane_idx[n_total*IW +: IW]   = IW'(ii);
        n_total                      = n_total + 1;
        last_grant                   = IW'(ii);
        any_grant                    = 1'b1;
        case (fu)
          FU_ALU:    n_alu = n_alu + 1;
          FU_MULT: begin
            took_mult  = 1'b1;
            mult_grant = 1'b1;
          end
          FU_MEM:    took_mem = 1'b1;
          FU_BRANCH: took_br  = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin : next_state
    rr_next       = any_grant ? (last_grant + IW'(1)) : rr_ptr;
    mult_cnt_next = mult_cnt;
    if (mult_grant) begin
      mult_cnt_next = CW'(MULT_LATENCY - 1);
    end else if (mult_busy_q) begin
      mult_cnt_next = mult_cnt - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr   <= '0;
      mult_cnt <= '0;
    end else begin
      rr_ptr   <= rr_next;
      mult_cnt <= mult_cnt_next;
    end
  end

  always_comb begin : outputs
    rs_data_issuing = '0;
    issue_valid     = '0;
    issue_idx       = '0;
    mult_busy       = 1'b0;
    if (!reset) begin
      rs_data_issuing = grant;
      issue_valid     = lane_valid;
      issue_idx       = lane_idx;
      mult_busy       = mult_busy_q;
    end
  end

endmodule
